// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage and a variable-latency data memory.
// The master (mem_stage) raises mem_req with mem_we/mem_addr/mem_wdata held stable.
// The slave (memory) answers with mem_ready; mem_rdata is valid while mem_ready is high.
//   mem_req   : access request (master -> slave)
//   mem_we    : 1 = write, 0 = read (master -> slave)
//   mem_addr  : 16-bit byte address (master -> slave)
//   mem_wdata : 16-bit write data (master -> slave)
//   mem_rdata : 16-bit read data (slave -> master)
//   mem_ready : access complete (slave -> master)
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the 16-bit pipelined CPU.
// Sits between EX/MEM and MEM/WB. A load or store is issued combinationally in
// the cycle it arrives. The access then waits in BUSY for mem_ready, with a
// TIMEOUT-cycle watchdog, and retires through a single DONE cycle. While the
// access is outstanding the front of the pipeline is stalled and a bubble goes
// to MEM/WB. Store data is forwarded from the WB stage when it targets the
// store's source register.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_*                : instruction fields from EX/MEM
//   wb_RegWrite/DstReg/data : WB-stage write, used for store-data forwarding
//   mem                 : data-memory bus (master side)
//   stall               : hold PC, IF/ID, ID/EX and EX/MEM
//   mem_err             : one-cycle pulse when an access times out
//   out_*               : instruction fields to MEM/WB
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_ALU_result,
  input  logic [15:0] in_storeData,
  input  logic [3:0]  in_SrcReg2,
  input  logic        in_MemRead,
  input  logic        in_MemWrite,
  input  logic        in_MemToReg,
  input  logic        in_RegWrite,
  input  logic        in_HLT,
  input  logic [3:0]  in_DstReg,
  input  logic        wb_RegWrite,
  input  logic [3:0]  wb_DstReg,
  input  logic [15:0] wb_data,
  mem_stage_if.master mem,
  output logic        stall,
  output logic        mem_err,
  output logic [15:0] out_ALU_result,
  output logic [15:0] out_memData,
  output logic        out_MemToReg,
  output logic        out_RegWrite,
  output logic        out_HLT,
  output logic [3:0]  out_DstReg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The counter starts at 0 on entry to BUSY, so its last wait cycle is TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        m2r_q, m2r_d;
  logic        rw_q, rw_d;
  logic        hlt_q, hlt_d;
  logic [3:0]  dst_q, dst_d;

  logic        access;
  logic        issue;
  logic        fwd_hit;
  logic [15:0] fwd_data;

  always_comb begin
    access   = in_MemRead | in_MemWrite;
    // Gating with rst_n keeps mem_req/stall low while reset is asserted even
    // though the held instruction may still be a load or store.
    issue    = (state_q == S_IDLE) & access & rst_n;
    // R0 is hard-wired zero, so a WB write to it never forwards.
    fwd_hit  = wb_RegWrite && (wb_DstReg == in_SrcReg2) && (wb_DstReg != 4'd0);
    fwd_data = fwd_hit ? wb_data : in_storeData;
  end

  // Next-state and latch update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    m2r_d   = m2r_q;
    rw_d    = rw_q;
    hlt_d   = hlt_q;
    dst_d   = dst_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          addr_d  = in_ALU_result;
          we_d    = in_MemWrite;
          wdata_d = fwd_data;
          m2r_d   = in_MemToReg;
          rw_d    = in_RegWrite;
          hlt_d   = in_HLT;
          dst_d   = in_DstReg;
          rdata_d = mem.mem_rdata;
          cnt_d   = 8'd0;
          state_d = mem.mem_ready ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        // mem_ready wins over a simultaneous timeout.
        if (mem.mem_ready) begin
          rdata_d = mem.mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          rdata_d = 16'h0000;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      hlt_q   <= 1'b0;
      dst_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
      hlt_q   <= hlt_d;
      dst_q   <= dst_d;
    end
  end

  // Memory bus and MEM/WB outputs
  always_comb begin
    mem.mem_req    = 1'b0;
    mem.mem_we     = 1'b0;
    mem.mem_addr   = in_ALU_result;
    mem.mem_wdata  = fwd_data;
    stall          = 1'b0;
    out_ALU_result = in_ALU_result;
    out_memData    = 16'h0000;
    out_MemToReg   = in_MemToReg;
    out_RegWrite   = in_RegWrite;
    out_HLT        = in_HLT;
    out_DstReg     = in_DstReg;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          mem.mem_req = 1'b1;
          mem.mem_we  = in_MemWrite;
          stall       = 1'b1;
        end
      end
      S_BUSY: begin
        mem.mem_req    = 1'b1;
        mem.mem_we     = we_q;
        mem.mem_addr   = addr_q;
        mem.mem_wdata  = wdata_q;
        stall          = 1'b1;
        out_ALU_result = addr_q;
        out_MemToReg   = m2r_q;
        out_DstReg     = dst_q;
      end
      S_DONE: begin
        out_ALU_result = addr_q;
        out_memData    = we_q ? 16'h0000 : rdata_q;
        out_MemToReg   = m2r_q;
        out_RegWrite   = rw_q;
        out_HLT        = hlt_q;
        out_DstReg     = dst_q;
      end
      default: begin
      end
    endcase

    // Bubble to MEM/WB while the access is outstanding.
    if (stall) begin
      out_RegWrite = 1'b0;
      out_HLT      = 1'b0;
    end
  end

  assign mem_err = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (TIMEOUT = 4): directed instructions push
// their expected MEM/WB result and memory request; a monitor and a memory
// model pop and compare whenever the DUT retires or requests.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_ALU_result, in_storeData;
  logic [3:0]  in_SrcReg2, in_DstReg;
  logic        in_MemRead, in_MemWrite, in_MemToReg, in_RegWrite, in_HLT;
  logic        wb_RegWrite;
  logic [3:0]  wb_DstReg;
  logic [15:0] wb_data;
  logic        stall, mem_err;
  logic [15:0] out_ALU_result, out_memData;
  logic        out_MemToReg, out_RegWrite, out_HLT;
  logic [3:0]  out_DstReg;

  mem_stage_if mem_bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_ALU_result  (in_ALU_result),
    .in_storeData   (in_storeData),
    .in_SrcReg2     (in_SrcReg2),
    .in_MemRead     (in_MemRead),
    .in_MemWrite    (in_MemWrite),
    .in_MemToReg    (in_MemToReg),
    .in_RegWrite    (in_RegWrite),
    .in_HLT         (in_HLT),
    .in_DstReg      (in_DstReg),
    .wb_RegWrite    (wb_RegWrite),
    .wb_DstReg      (wb_DstReg),
    .wb_data        (wb_data),
    .mem            (mem_bus),
    .stall          (stall),
    .mem_err        (mem_err),
    .out_ALU_result (out_ALU_result),
    .out_memData    (out_memData),
    .out_MemToReg   (out_MemToReg),
    .out_RegWrite   (out_RegWrite),
    .out_HLT        (out_HLT),
    .out_DstReg     (out_DstReg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu;
    logic [15:0] mdata;
    logic        rw;
    logic        hlt;
    logic        m2r;
    logic [3:0]  dst;
  } ret_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  ret_t        ret_q[$];
  req_t        req_q[$];
  ret_t        mon_e;
  req_t        mcur;
  int          checks = 0;
  int          failures = 0;
  int          lat = 0;
  logic [15:0] rd_val = 16'h0000;
  int          req_cyc = 0;
  int          req_total = 0;
  int          err_cnt = 0;
  bit          ins_vld = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Memory model: ready in the lat-th request cycle (lat = 0 never answers).
  always @(negedge clk) begin
    if (mem_bus.mem_req === 1'b1) begin
      req_cyc++;
      req_total++;
      if (req_cyc == 1) begin
        if (req_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req addr=%0h", mem_bus.mem_addr);
          mcur = '{we: mem_bus.mem_we, addr: mem_bus.mem_addr, wdata: mem_bus.mem_wdata};
        end else begin
          mcur = req_q.pop_front();
        end
      end
      chk("mem_we", 32'(mem_bus.mem_we), 32'(mcur.we));
      chk("mem_addr", 32'(mem_bus.mem_addr), 32'(mcur.addr));
      if (mcur.we) chk("mem_wdata", 32'(mem_bus.mem_wdata), 32'(mcur.wdata));
      mem_bus.mem_ready = (lat != 0) && (req_cyc == lat);
      mem_bus.mem_rdata = ((lat != 0) && (req_cyc == lat)) ? rd_val : 16'hDEAD;
    end else begin
      req_cyc           = 0;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 16'hDEAD;
    end
    if (mem_err === 1'b1) err_cnt++;
  end

  // Retire monitor: bubbles while stalled, scoreboard compare when an instruction leaves.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) begin
        chk("bubble_rw", 32'(out_RegWrite), 32'd0);
        chk("bubble_hlt", 32'(out_HLT), 32'd0);
      end else if (ins_vld) begin
        if (ret_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire alu=%0h", out_ALU_result);
        end else begin
          mon_e = ret_q.pop_front();
          chk("out_alu", 32'(out_ALU_result), 32'(mon_e.alu));
          chk("out_memData", 32'(out_memData), 32'(mon_e.mdata));
          chk("out_rw", 32'(out_RegWrite), 32'(mon_e.rw));
          chk("out_hlt", 32'(out_HLT), 32'(mon_e.hlt));
          chk("out_m2r", 32'(out_MemToReg), 32'(mon_e.m2r));
          chk("out_dst", 32'(out_DstReg), 32'(mon_e.dst));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input string nm, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [3:0] src, input logic [3:0] dst,
                       input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic hlt, input int n_lat, input logic [15:0] rdv,
                       input logic [15:0] exp_md, input logic [15:0] exp_wd,
                       input int exp_stall, input int exp_req, input int exp_err,
                       input bit chg_wb);
    int st;
    bit done;
    st   = 0;
    done = 1'b0;
    in_ALU_result = alu;
    in_storeData  = sd;
    in_SrcReg2    = src;
    in_DstReg     = dst;
    in_MemRead    = mr;
    in_MemWrite   = mw;
    in_MemToReg   = m2r;
    in_RegWrite   = rw;
    in_HLT        = hlt;
    lat           = n_lat;
    rd_val        = rdv;
    req_total     = 0;
    err_cnt       = 0;
    ins_vld       = 1'b1;
    if (mr | mw) req_q.push_back('{we: mw, addr: alu, wdata: exp_wd});
    ret_q.push_back('{alu: alu, mdata: exp_md, rw: rw, hlt: hlt, m2r: m2r, dst: dst});
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        st++;
        // The latch happened at the first edge; later WB changes must not leak through.
        if (chg_wb && i == 1) wb_data = ~wb_data;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_retire_timeout stall_cycles=%0d", nm, st);
    end
    chk({nm, "_stall_cycles"}, st, exp_stall);
    @(posedge clk);
    #1;
    in_MemRead  = 1'b0;
    in_MemWrite = 1'b0;
    in_RegWrite = 1'b0;
    in_HLT      = 1'b0;
    ins_vld     = 1'b0;
    // One idle cycle so a duplicate request or a stray error pulse is counted.
    @(negedge clk);
    #1;
    chk({nm, "_req_cycles"}, req_total, exp_req);
    chk({nm, "_err_pulses"}, err_cnt, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    in_ALU_result = 16'hCAFE;
    in_storeData  = 16'h0000;
    in_SrcReg2    = 4'd0;
    in_DstReg     = 4'd9;
    in_MemRead    = 1'b1;
    in_MemWrite   = 1'b0;
    in_MemToReg   = 1'b0;
    in_RegWrite   = 1'b1;
    in_HLT        = 1'b0;
    wb_RegWrite   = 1'b0;
    wb_DstReg     = 4'd0;
    wb_data       = 16'h0000;

    // In reset: no request, no stall, inputs pass straight through.
    #12;
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_out_alu", 32'(out_ALU_result), 32'hCAFE);
    chk("rst_out_rw", 32'(out_RegWrite), 32'd1);
    chk("rst_out_dst", 32'(out_DstReg), 32'd9);
    chk("rst_out_memData", 32'(out_memData), 32'd0);
    in_MemRead  = 1'b0;
    in_RegWrite = 1'b0;
    #6;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //     name        alu       sd        src   dst   mr mw m2r rw hlt lat rdata     md        wd        st req err chg
    issue("alu",      16'h1234, 16'h0000, 4'd0, 4'd5, 0, 0, 0,  1, 0,  0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0);
    issue("ld3",      16'h0040, 16'h1111, 4'd1, 4'd7, 1, 0, 1,  1, 0,  3, 16'hBEEF, 16'hBEEF, 16'h0000, 3, 3, 0,  0);

    wb_RegWrite = 1'b1; wb_DstReg = 4'd3; wb_data = 16'hA5A5;
    issue("st_fwd",   16'h0100, 16'h0000, 4'd3, 4'd0, 0, 1, 0,  0, 0,  3, 16'h0000, 16'h0000, 16'hA5A5, 3, 3, 0,  1);
    wb_RegWrite = 1'b1; wb_DstReg = 4'd0; wb_data = 16'hA5A5;
    issue("st_r0",    16'h0102, 16'h0000, 4'd0, 4'd0, 0, 1, 0,  0, 0,  3, 16'h0000, 16'h0000, 16'h0000, 3, 3, 0,  1);
    wb_RegWrite = 1'b1; wb_DstReg = 4'd4; wb_data = 16'hA5A5;
    issue("st_nofwd", 16'h0104, 16'h7777, 4'd3, 4'd0, 0, 1, 0,  0, 0,  2, 16'h0000, 16'h0000, 16'h7777, 2, 2, 0,  0);
    wb_RegWrite = 1'b0; wb_DstReg = 4'd0; wb_data = 16'h0000;

    issue("ld0",      16'h0080, 16'h0000, 4'd0, 4'd2, 1, 0, 1,  1, 0,  1, 16'h1357, 16'h1357, 16'h0000, 1, 1, 0,  0);
    issue("ld_to",    16'h00C0, 16'h0000, 4'd0, 4'd4, 1, 0, 1,  1, 0,  0, 16'h0000, 16'h0000, 16'h0000, 5, 5, 1,  0);
    issue("ld_last",  16'h00C2, 16'h0000, 4'd0, 4'd6, 1, 0, 1,  1, 0,  5, 16'h2468, 16'h2468, 16'h0000, 5, 5, 0,  0);
    issue("rw_both",  16'h0200, 16'h0F0F, 4'd8, 4'd1, 1, 1, 1,  0, 0,  2, 16'h9999, 16'h0000, 16'h0F0F, 2, 2, 0,  0);
    issue("ld_hlt",   16'h0300, 16'h0000, 4'd0, 4'd3, 1, 0, 1,  1, 1,  2, 16'h4242, 16'h4242, 16'h0000, 2, 2, 0,  0);

    // Reset while BUSY: request and stall drop at once, the access is abandoned.
    in_ALU_result = 16'h0400;
    in_DstReg     = 4'd5;
    in_MemRead    = 1'b1;
    in_RegWrite   = 1'b1;
    in_MemToReg   = 1'b1;
    lat           = 0;
    req_q.push_back('{we: 1'b0, addr: 16'h0400, wdata: 16'h0000});
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("busy_mem_req", 32'(mem_bus.mem_req), 32'd1);
    chk("busy_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_mem_err", 32'(mem_err), 32'd0);
    chk("midrst_out_rw", 32'(out_RegWrite), 32'd1);
    chk("midrst_out_alu", 32'(out_ALU_result), 32'h0400);
    in_MemRead  = 1'b0;
    in_RegWrite = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("ld_after_rst", 16'h0042, 16'h0000, 4'd0, 4'd9, 1, 0, 1, 1, 0, 2, 16'h0ACE, 16'h0ACE, 16'h0000, 2, 2, 0, 0);

    chk("ret_q_drained", ret_q.size(), 32'd0);
    chk("req_q_drained", req_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
